// File: rtl/data_sram_bridge.sv
// Memory-stage to SRAM-like data bus bridge: one outstanding req/addr_ok/data_ok transaction.
// Optional DATA_BRIDGE_KSEG_MAP_EN clears addr[31:29] for kseg0/kseg1 bus addresses.
module data_sram_bridge #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [3:0]        mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [ADDR_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_rdata,
    input  logic              longest_stall,
    output logic              d_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [ADDR_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [ADDR_W-1:0] data_rdata,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              wr_q, wr_d;
    logic              is_wr_q, is_wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] rdata_q, rdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              d_stall_c;

    function automatic logic [1:0] size_of(input logic [3:0] wen);
        logic [1:0] sz;
        case (wen)
            4'b1111:                            sz = 2'd2;
            4'b0011, 4'b1100:                   sz = 2'd1;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sz = 2'd0;
            default:                            sz = 2'd2;
        endcase
        return sz;
    endfunction

    function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] m;
        m = a;
`ifdef DATA_BRIDGE_KSEG_MAP_EN
        if (a[ADDR_W-1 -: 2] == 2'b10) begin
            m[ADDR_W-1 -: 3] = 3'b000;
        end
`endif
        return m;
    endfunction

    // Next-state, request fields and read-data capture
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        wr_d      = wr_q;
        is_wr_d   = is_wr_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        d_stall_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_en) begin
                    d_stall_c = 1'b1;
                    state_d   = ADDR;
                    req_d     = 1'b1;
                    wr_d      = |mem_wen;
                    is_wr_d   = |mem_wen;
                    if (|mem_wen) begin
                        size_d  = size_of(mem_wen);
                        addr_d  = map_addr(mem_addr);
                        wdata_d = mem_wdata;
                    end else begin
                        // Byte/half extraction of loads happens in writeback
                        size_d  = 2'd2;
                        addr_d  = map_addr({mem_addr[ADDR_W-1:2], 2'b00});
                        wdata_d = '0;
                    end
                end
            end
            ADDR: begin
                d_stall_c = 1'b1;
                if (data_addr_ok) begin
                    req_d   = 1'b0;
                    wr_d    = 1'b0;
                    size_d  = 2'd0;
                    addr_d  = '0;
                    wdata_d = '0;
                    if (data_data_ok) begin
                        state_d = DONE;
                        if (!is_wr_q) rdata_d = data_rdata;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                d_stall_c = 1'b1;
                if (data_data_ok) begin
                    state_d = DONE;
                    if (!is_wr_q) rdata_d = data_rdata;
                end
            end
            DONE: begin
                if (!longest_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cnt_d = cnt_q + CNT_W'(d_stall_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            is_wr_q <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            wr_q    <= wr_d;
            is_wr_q <= is_wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign d_stall      = d_stall_c;
    assign data_req     = req_q;
    assign data_wr      = wr_q;
    assign data_size    = size_q;
    assign data_addr    = addr_q;
    assign data_wdata   = wdata_q;
    assign mem_rdata    = rdata_q;
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge: directed vector table, reset corner case, random transactions.
module tb_data_sram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        longest_stall, ext_stall;
    logic        d_stall, data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] stall_cycles;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] model_rdata;
    logic [31:0] model_cnt;

    always #5 clk = ~clk;

    // Global stall: this bridge's stall plus any other source (i_stall, div)
    assign longest_stall = d_stall | ext_stall;

    data_sram_bridge dut (
        .clk(clk), .rst(rst),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .longest_stall(longest_stall), .d_stall(d_stall),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .stall_cycles(stall_cycles)
    );

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          a_dly;
        int          d_dly;
        int          hold;
        logic [1:0]  exp_size;
        logic [31:0] exp_addr;
        int          exp_stalls;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_size(input logic [3:0] w);
        if (w == 4'b0000) return 2'd2;
        if ($countones(w) == 1) return 2'd0;
        if (w == 4'b0011 || w == 4'b1100) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] ref_addr(input logic [3:0] w, input logic [31:0] a);
        logic [31:0] r;
        r = (w == 4'b0000) ? (a & 32'hFFFF_FFFC) : a;
`ifdef DATA_BRIDGE_KSEG_MAP_EN
        if (r[31:29] == 3'b100 || r[31:29] == 3'b101) r = r & 32'h1FFF_FFFF;
`endif
        return r;
    endfunction

    // Entered just after a posedge with the bridge idle; leaves it idle the same way.
    task automatic run_txn(input vec_t v);
        int   stalls = 0, req_cyc = 0, since = 0, guard = 0;
        bit   accepted = 0, done = 0;
        logic [31:0] exp_rd;
        exp_rd    = (v.wen == 4'b0000) ? v.rdata : model_rdata;
        mem_en    = 1'b1;
        mem_wen   = v.wen;
        mem_addr  = v.addr;
        mem_wdata = v.wdata;
        while (!done && guard < 60) begin
            @(negedge clk);
            guard++;
            if (!d_stall) begin
                done = 1;
            end else begin
                stalls++;
                if (data_req) begin
                    chk("req_after_accept", 64'(accepted), 64'd0);
                    chk("data_wr", 64'(data_wr), 64'(v.wen != 4'b0000));
                    chk("data_size", 64'(data_size), 64'(v.exp_size));
                    chk("data_addr", 64'(data_addr), 64'(v.exp_addr));
                    if (v.wen != 4'b0000) chk("data_wdata", 64'(data_wdata), 64'(v.wdata));
                    if (req_cyc == v.a_dly) begin
                        data_addr_ok = 1'b1;
                        accepted     = 1;
                        since        = 0;
                        if (v.d_dly == 0) begin
                            data_data_ok = 1'b1;
                            data_rdata   = v.rdata;
                        end
                    end
                    req_cyc++;
                end else if (accepted) begin
                    since++;
                    if (since == v.d_dly) begin
                        data_data_ok = 1'b1;
                        data_rdata   = v.rdata;
                    end
                end
                @(posedge clk);
                #1;
                data_addr_ok = 1'b0;
                data_data_ok = 1'b0;
                data_rdata   = $urandom;
            end
        end
        chk("txn_done", 64'(done), 64'd1);
        chk("stall_len", 64'(stalls), 64'(v.exp_stalls));
        chk("mem_rdata_done", 64'(mem_rdata), 64'(exp_rd));
        model_cnt = model_cnt + 32'(v.exp_stalls);
        chk("stall_cycles", 64'(stall_cycles), 64'(model_cnt));
        model_rdata = exp_rd;
        ext_stall = (v.hold > 0);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            #1;
            data_rdata = $urandom;
            @(negedge clk);
            chk("hold_d_stall", 64'(d_stall), 64'd0);
            chk("hold_no_req", 64'(data_req), 64'd0);
            chk("hold_rdata", 64'(mem_rdata), 64'(exp_rd));
            if (h == v.hold - 1) ext_stall = 1'b0;
        end
        @(posedge clk);
        #1;
        mem_en  = 1'b0;
        mem_wen = 4'b0000;
        @(negedge clk);
        chk("idle_d_stall", 64'(d_stall), 64'd0);
        chk("idle_req", 64'(data_req), 64'd0);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[9];
    vec_t rv;
    logic [3:0] wen_pool[11];

    initial begin
        rst = 1'b1; mem_en = 1'b0; mem_wen = 4'b0; mem_addr = '0; mem_wdata = '0;
        ext_stall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
        model_rdata = '0; model_cnt = '0;

        //           wen      addr           wdata          rdata          a  d  h  size  exp_addr       stalls
        vecs[0] = '{4'b0000, 32'h0000_1000, 32'h0,         32'hDEADBEEF, 0, 1, 0, 2'd2, 32'h0000_1000, 3};
        vecs[1] = '{4'b0100, 32'h0000_1006, 32'h00AB_0000, 32'h5555_AAAA, 0, 1, 0, 2'd0, 32'h0000_1006, 3};
        vecs[2] = '{4'b0000, 32'h0000_2002, 32'h0,         32'h1234_5678, 3, 2, 0, 2'd2, 32'h0000_2000, 7};
        vecs[3] = '{4'b0000, 32'h0000_3000, 32'h0,         32'hCAFE_F00D, 0, 1, 3, 2'd2, 32'h0000_3000, 3};
        vecs[4] = '{4'b0000, 32'h0000_0047, 32'h0,         32'h0BAD_C0DE, 0, 0, 1, 2'd2, 32'h0000_0044, 2};
        vecs[5] = '{4'b1100, 32'h0000_0102, 32'hBEEF_0000, 32'h0,         1, 1, 0, 2'd1, 32'h0000_0102, 4};
`ifdef DATA_BRIDGE_KSEG_MAP_EN
        vecs[6] = '{4'b0000, 32'hBFC0_0004, 32'h0,         32'h0000_0F0F, 0, 1, 0, 2'd2, 32'h1FC0_0004, 3};
        vecs[7] = '{4'b1111, 32'h8000_0010, 32'h0102_0304, 32'h0,         0, 1, 0, 2'd2, 32'h0000_0010, 3};
`else
        vecs[6] = '{4'b0000, 32'hBFC0_0004, 32'h0,         32'h0000_0F0F, 0, 1, 0, 2'd2, 32'hBFC0_0004, 3};
        vecs[7] = '{4'b1111, 32'h8000_0010, 32'h0102_0304, 32'h0,         0, 1, 0, 2'd2, 32'h8000_0010, 3};
`endif
        vecs[8] = '{4'b0101, 32'h0000_0020, 32'h7777_0000, 32'h0,         2, 0, 0, 2'd2, 32'h0000_0020, 4};

        // Reset state
        @(negedge clk);
        chk("rst_req", 64'(data_req), 64'd0);
        chk("rst_d_stall", 64'(d_stall), 64'd0);
        chk("rst_rdata", 64'(mem_rdata), 64'd0);
        chk("rst_cnt", 64'(stall_cycles), 64'd0);
        chk("rst_addr", 64'(data_addr), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) run_txn(vecs[i]);

        // Reset while waiting in the data phase
        mem_en = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h0000_4000;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_req", 64'(data_req), 64'd1);
        data_addr_ok = 1'b1;
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        @(negedge clk);
        chk("data_phase_req", 64'(data_req), 64'd0);
        chk("data_phase_stall", 64'(d_stall), 64'd1);
        rst = 1'b1;
        mem_en = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_req", 64'(data_req), 64'd0);
        chk("mid_rst_d_stall", 64'(d_stall), 64'd0);
        chk("mid_rst_rdata", 64'(mem_rdata), 64'd0);
        chk("mid_rst_cnt", 64'(stall_cycles), 64'd0);
        rst = 1'b0;
        model_rdata = '0;
        model_cnt   = '0;
        @(posedge clk); #1;

        // Random transactions against the reference model
        wen_pool = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b1000,
                     4'b0011, 4'b1100, 4'b1111, 4'b0110, 4'b1011};
        for (int n = 0; n < 40; n++) begin
            rv.wen        = wen_pool[$urandom_range(10, 0)];
            rv.addr       = $urandom;
            rv.wdata      = $urandom;
            rv.rdata      = $urandom;
            rv.a_dly      = int'($urandom_range(4, 0));
            rv.d_dly      = int'($urandom_range(3, 0));
            rv.hold       = int'($urandom_range(2, 0));
            rv.exp_size   = ref_size(rv.wen);
            rv.exp_addr   = ref_addr(rv.wen, rv.addr);
            rv.exp_stalls = 2 + rv.a_dly + rv.d_dly;
            run_txn(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
